// File: rtl/pipeline_pkg.sv
// Shared pipeline constants: control-bundle layout and datapath widths.
// Used by the control unit, ID/EX and EX/MEM stages so bit positions never drift.
package pipeline_pkg;

   localparam int DATA_W = 32;
   localparam int REG_W  = 5;
   localparam int CTRL_W = 10;

   localparam int CTRL_JUMP       = 0;
   localparam int CTRL_ALU_OP_LO  = 1;
   localparam int CTRL_ALU_OP_HI  = 2;
   localparam int CTRL_REG_DST    = 3;
   localparam int CTRL_ALU_SRC    = 4;
   localparam int CTRL_BRANCH     = 5;
   localparam int CTRL_MEM_WRITE  = 6;
   localparam int CTRL_MEM_READ   = 7;
   localparam int CTRL_MEM_TO_REG = 8;
   localparam int CTRL_REG_WRITE  = 9;

   // Register $zero is never a real producer, so it can never cause a dependency.
   function automatic logic reg_match(input logic [REG_W-1:0] prod, input logic [REG_W-1:0] cons);
      return (prod != '0) && (prod == cons);
   endfunction

endpackage

// File: rtl/hazard_detect.sv
// Load-use hazard compare between the load in EX and the instruction in decode.
// Purely combinational; no state, no backpressure of its own.
module hazard_detect
   import pipeline_pkg::*;
(
   input  logic             ex_valid,
   input  logic             ex_mem_read,
   input  logic [REG_W-1:0] ex_rt,
   input  logic             id_valid,
   input  logic [REG_W-1:0] id_rs,
   input  logic [REG_W-1:0] id_rt,
   input  logic             id_uses_rt,
   output logic             hazard
);

   logic rs_hit;
   logic rt_hit;

   assign rs_hit = reg_match(ex_rt, id_rs);
   assign rt_hit = id_uses_rt & reg_match(ex_rt, id_rt);
   assign hazard = ex_valid & ex_mem_read & id_valid & (rs_hit | rt_hit);

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register, one cycle latency; inserts a bubble on flush, load-use stall or empty slot.
// stall freezes PC and IF/ID upstream; a flush always wins over a stall.
module id_ex_stage #(
   parameter int CTRL_W = pipeline_pkg::CTRL_W,
   parameter int CNT_W  = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              id_valid,
   input  logic [31:0]       id_pc4,
   input  logic [31:0]       id_read_data1,
   input  logic [31:0]       id_read_data2,
   input  logic [31:0]       id_imm,
   input  logic [4:0]        id_rs,
   input  logic [4:0]        id_rt,
   input  logic [4:0]        id_rd,
   input  logic              id_uses_rt,
   input  logic [CTRL_W-1:0] id_ctrl,
   input  logic              flush,
   output logic              ex_valid,
   output logic [31:0]       ex_pc4,
   output logic [31:0]       ex_read_data1,
   output logic [31:0]       ex_read_data2,
   output logic [31:0]       ex_imm,
   output logic [4:0]        ex_rs,
   output logic [4:0]        ex_rt,
   output logic [4:0]        ex_rd,
   output logic [CTRL_W-1:0] ex_ctrl,
   output logic              stall,
   output logic [CNT_W-1:0]  stall_count,
   output logic [CNT_W-1:0]  flush_count
);

   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   logic              ex_valid_q,  ex_valid_d;
   logic [31:0]       ex_pc4_q,    ex_pc4_d;
   logic [31:0]       ex_rd1_q,    ex_rd1_d;
   logic [31:0]       ex_rd2_q,    ex_rd2_d;
   logic [31:0]       ex_imm_q,    ex_imm_d;
   logic [4:0]        ex_rs_q,     ex_rs_d;
   logic [4:0]        ex_rt_q,     ex_rt_d;
   logic [4:0]        ex_rd_q,     ex_rd_d;
   logic [CTRL_W-1:0] ex_ctrl_q,   ex_ctrl_d;
   logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
   logic [CNT_W-1:0]  flush_cnt_q, flush_cnt_d;

   logic hazard;
   logic bubble;

   hazard_detect u_hazard_detect (
      .ex_valid    (ex_valid_q),
      .ex_mem_read (ex_ctrl_q[pipeline_pkg::CTRL_MEM_READ]),
      .ex_rt       (ex_rt_q),
      .id_valid    (id_valid),
      .id_rs       (id_rs),
      .id_rt       (id_rt),
      .id_uses_rt  (id_uses_rt),
      .hazard      (hazard)
   );

   assign stall  = hazard & ~flush;
   assign bubble = flush | stall | ~id_valid;

   always_comb begin
      ex_valid_d = 1'b0;
      ex_pc4_d   = '0;
      ex_rd1_d   = '0;
      ex_rd2_d   = '0;
      ex_imm_d   = '0;
      ex_rs_d    = '0;
      ex_rt_d    = '0;
      ex_rd_d    = '0;
      ex_ctrl_d  = '0;
      if (!bubble) begin
         ex_valid_d = 1'b1;
         ex_pc4_d   = id_pc4;
         ex_rd1_d   = id_read_data1;
         ex_rd2_d   = id_read_data2;
         ex_imm_d   = id_imm;
         ex_rs_d    = id_rs;
         ex_rt_d    = id_rt;
         ex_rd_d    = id_rd;
         ex_ctrl_d  = id_ctrl;
      end
   end

   // Event counters stick at all-ones rather than wrapping.
   always_comb begin
      stall_cnt_d = stall_cnt_q;
      flush_cnt_d = flush_cnt_q;
      if (stall && (stall_cnt_q != CNT_MAX)) begin
         stall_cnt_d = stall_cnt_q + CNT_W'(1);
      end
      if (flush && id_valid && (flush_cnt_q != CNT_MAX)) begin
         flush_cnt_d = flush_cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         ex_valid_q  <= 1'b0;
         ex_pc4_q    <= '0;
         ex_rd1_q    <= '0;
         ex_rd2_q    <= '0;
         ex_imm_q    <= '0;
         ex_rs_q     <= '0;
         ex_rt_q     <= '0;
         ex_rd_q     <= '0;
         ex_ctrl_q   <= '0;
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         ex_valid_q  <= ex_valid_d;
         ex_pc4_q    <= ex_pc4_d;
         ex_rd1_q    <= ex_rd1_d;
         ex_rd2_q    <= ex_rd2_d;
         ex_imm_q    <= ex_imm_d;
         ex_rs_q     <= ex_rs_d;
         ex_rt_q     <= ex_rt_d;
         ex_rd_q     <= ex_rd_d;
         ex_ctrl_q   <= ex_ctrl_d;
         stall_cnt_q <= stall_cnt_d;
         flush_cnt_q <= flush_cnt_d;
      end
   end

   assign ex_valid      = ex_valid_q;
   assign ex_pc4        = ex_pc4_q;
   assign ex_read_data1 = ex_rd1_q;
   assign ex_read_data2 = ex_rd2_q;
   assign ex_imm        = ex_imm_q;
   assign ex_rs         = ex_rs_q;
   assign ex_rt         = ex_rt_q;
   assign ex_rd         = ex_rd_q;
   assign ex_ctrl       = ex_ctrl_q;
   assign stall_count   = stall_cnt_q;
   assign flush_count   = flush_cnt_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: vector table plus reset-mid-stall and counter saturation sequences.
module tb_id_ex_stage;

   localparam logic [9:0] LW_CTRL   = 10'h390;
   localparam logic [9:0] R_CTRL    = 10'h20C;
   localparam logic [9:0] SW_CTRL   = 10'h050;
   localparam logic [9:0] ADDI_CTRL = 10'h210;

   logic        clk = 1'b0;
   logic        reset;
   logic        id_valid;
   logic [31:0] id_pc4, id_read_data1, id_read_data2, id_imm;
   logic [4:0]  id_rs, id_rt, id_rd;
   logic        id_uses_rt;
   logic [9:0]  id_ctrl;
   logic        flush;

   logic        ex_valid, stall;
   logic [31:0] ex_pc4, ex_read_data1, ex_read_data2, ex_imm;
   logic [4:0]  ex_rs, ex_rt, ex_rd;
   logic [9:0]  ex_ctrl;
   logic [15:0] stall_count, flush_count;

   logic        ex_valid4, stall4;
   logic [31:0] ex_pc4_4, ex_read_data1_4, ex_read_data2_4, ex_imm_4;
   logic [4:0]  ex_rs_4, ex_rt_4, ex_rd_4;
   logic [9:0]  ex_ctrl_4;
   logic [3:0]  stall_count4, flush_count4;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   id_ex_stage dut (
      .clk(clk), .reset(reset), .id_valid(id_valid), .id_pc4(id_pc4),
      .id_read_data1(id_read_data1), .id_read_data2(id_read_data2), .id_imm(id_imm),
      .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .id_uses_rt(id_uses_rt),
      .id_ctrl(id_ctrl), .flush(flush), .ex_valid(ex_valid), .ex_pc4(ex_pc4),
      .ex_read_data1(ex_read_data1), .ex_read_data2(ex_read_data2), .ex_imm(ex_imm),
      .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd), .ex_ctrl(ex_ctrl), .stall(stall),
      .stall_count(stall_count), .flush_count(flush_count)
   );

   id_ex_stage #(.CNT_W(4)) dut4 (
      .clk(clk), .reset(reset), .id_valid(id_valid), .id_pc4(id_pc4),
      .id_read_data1(id_read_data1), .id_read_data2(id_read_data2), .id_imm(id_imm),
      .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .id_uses_rt(id_uses_rt),
      .id_ctrl(id_ctrl), .flush(flush), .ex_valid(ex_valid4), .ex_pc4(ex_pc4_4),
      .ex_read_data1(ex_read_data1_4), .ex_read_data2(ex_read_data2_4), .ex_imm(ex_imm_4),
      .ex_rs(ex_rs_4), .ex_rt(ex_rt_4), .ex_rd(ex_rd_4), .ex_ctrl(ex_ctrl_4), .stall(stall4),
      .stall_count(stall_count4), .flush_count(flush_count4)
   );

   typedef struct {
      logic        valid;
      logic [31:0] pc4, rd1, rd2, imm;
      logic [4:0]  rs, rt, rd;
      logic        uses_rt;
      logic [9:0]  ctrl;
      logic        flush;
      logic        exp_stall;
      logic        exp_valid;
      logic [15:0] exp_sc;
      logic [15:0] exp_fc;
   } vec_t;

   vec_t vecs[16];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic drive(input vec_t v);
      id_valid      = v.valid;
      id_pc4        = v.pc4;
      id_read_data1 = v.rd1;
      id_read_data2 = v.rd2;
      id_imm        = v.imm;
      id_rs         = v.rs;
      id_rt         = v.rt;
      id_rd         = v.rd;
      id_uses_rt    = v.uses_rt;
      id_ctrl       = v.ctrl;
      flush         = v.flush;
   endtask

   task automatic drive_lw();
      drive('{1'b1, 32'h200, 32'h1000, 32'h0, 32'h4, 5'd8, 5'd9, 5'd0, 1'b0, LW_CTRL, 1'b0,
              1'b0, 1'b0, 16'h0, 16'h0});
   endtask

   task automatic drive_use();
      drive('{1'b1, 32'h204, 32'h1, 32'h2, 32'h0, 5'd9, 5'd10, 5'd11, 1'b1, R_CTRL, 1'b0,
              1'b0, 1'b0, 16'h0, 16'h0});
   endtask

   initial begin
      //          valid pc4       rd1       rd2           imm    rs  rt  rd  urt ctrl       fl   stl vld sc  fc
      vecs[0]  = '{1, 32'h104, 32'h1000, 32'h0,        32'h4,  8,  9,  0,  0, LW_CTRL,   0,   0, 1,  0, 0};
      vecs[1]  = '{1, 32'h108, 32'h1,    32'h2,        32'h0,  9, 10, 11,  1, R_CTRL,    0,   1, 0,  1, 0};
      vecs[2]  = '{1, 32'h108, 32'h1,    32'h2,        32'h0,  9, 10, 11,  1, R_CTRL,    0,   0, 1,  1, 0};
      vecs[3]  = '{1, 32'h10C, 32'h1000, 32'h0,        32'h8,  8,  0,  0,  0, LW_CTRL,   0,   0, 1,  1, 0};
      vecs[4]  = '{1, 32'h110, 32'h3,    32'h55,       32'h0,  0,  0, 12,  1, R_CTRL,    0,   0, 1,  1, 0};
      vecs[5]  = '{1, 32'h114, 32'h1000, 32'h0,        32'hC,  8,  9,  0,  0, LW_CTRL,   0,   0, 1,  1, 0};
      vecs[6]  = '{1, 32'h118, 32'h3,    32'hDEADBEEF, 32'h10, 3,  9,  0,  0, ADDI_CTRL, 0,   0, 1,  1, 0};
      vecs[7]  = '{1, 32'h11C, 32'h1000, 32'h0,        32'h14, 8,  9,  0,  0, LW_CTRL,   0,   0, 1,  1, 0};
      vecs[8]  = '{1, 32'h120, 32'h1,    32'h7,        32'h0,  9, 10, 11,  1, R_CTRL,    1,   0, 0,  1, 1};
      vecs[9]  = '{0, 32'h124, 32'h1,    32'h77,       32'h0,  9, 10, 11,  1, R_CTRL,    0,   0, 0,  1, 1};
      vecs[10] = '{0, 32'h128, 32'h1,    32'h77,       32'h0,  9, 10, 11,  1, R_CTRL,    1,   0, 0,  1, 1};
      vecs[11] = '{1, 32'h12C, 32'h1000, 32'h0,        32'h18, 8,  9,  0,  0, LW_CTRL,   0,   0, 1,  1, 1};
      vecs[12] = '{1, 32'h130, 32'h4,    32'hAA,       32'h20, 4,  9,  0,  1, SW_CTRL,   0,   1, 0,  2, 1};
      vecs[13] = '{1, 32'h134, 32'h1000, 32'h0,        32'h1C, 8,  9,  0,  0, LW_CTRL,   0,   0, 1,  2, 1};
      vecs[14] = '{0, 32'h138, 32'h5,    32'hBB,       32'h0,  9,  9, 13,  1, R_CTRL,    0,   0, 0,  2, 1};
      vecs[15] = '{1, 32'h13C, 32'h1000, 32'h0,        32'h20, 8,  9,  0,  0, LW_CTRL,   0,   0, 1,  2, 1};

      reset = 1'b1;
      drive_use();
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      check("reset_ex_valid", 32'(ex_valid), 32'h0);
      check("reset_ex_ctrl", 32'(ex_ctrl), 32'h0);
      check("reset_ex_pc4", ex_pc4, 32'h0);
      check("reset_stall", 32'(stall), 32'h0);
      check("reset_stall_count", 32'(stall_count), 32'h0);
      check("reset_flush_count", 32'(flush_count), 32'h0);

      for (int i = 0; i < 16; i++) begin
         @(negedge clk);
         drive(vecs[i]);
         #1;
         check($sformatf("v%0d_stall", i), 32'(stall), 32'(vecs[i].exp_stall));
         @(posedge clk);
         #1;
         check($sformatf("v%0d_ex_valid", i), 32'(ex_valid), 32'(vecs[i].exp_valid));
         check($sformatf("v%0d_ex_ctrl", i), 32'(ex_ctrl), vecs[i].exp_valid ? 32'(vecs[i].ctrl) : 32'h0);
         check($sformatf("v%0d_ex_pc4", i), ex_pc4, vecs[i].exp_valid ? vecs[i].pc4 : 32'h0);
         check($sformatf("v%0d_ex_rd1", i), ex_read_data1, vecs[i].exp_valid ? vecs[i].rd1 : 32'h0);
         check($sformatf("v%0d_ex_rd2", i), ex_read_data2, vecs[i].exp_valid ? vecs[i].rd2 : 32'h0);
         check($sformatf("v%0d_ex_imm", i), ex_imm, vecs[i].exp_valid ? vecs[i].imm : 32'h0);
         check($sformatf("v%0d_ex_rs", i), 32'(ex_rs), vecs[i].exp_valid ? 32'(vecs[i].rs) : 32'h0);
         check($sformatf("v%0d_ex_rt", i), 32'(ex_rt), vecs[i].exp_valid ? 32'(vecs[i].rt) : 32'h0);
         check($sformatf("v%0d_ex_rd", i), 32'(ex_rd), vecs[i].exp_valid ? 32'(vecs[i].rd) : 32'h0);
         check($sformatf("v%0d_stall_count", i), 32'(stall_count), 32'(vecs[i].exp_sc));
         check($sformatf("v%0d_flush_count", i), 32'(flush_count), 32'(vecs[i].exp_fc));
         check($sformatf("v%0d_stall_count4", i), 32'(stall_count4), 32'(vecs[i].exp_sc[3:0]));
      end

      // Reset lands while a load-use stall is being signalled.
      @(negedge clk);
      drive_use();
      reset = 1'b1;
      #1;
      check("midstall_stall_before", 32'(stall), 32'h1);
      @(posedge clk);
      #1;
      reset = 1'b0;
      check("midstall_ex_valid", 32'(ex_valid), 32'h0);
      check("midstall_ex_ctrl", 32'(ex_ctrl), 32'h0);
      check("midstall_ex_pc4", ex_pc4, 32'h0);
      check("midstall_ex_rd2", ex_read_data2, 32'h0);
      check("midstall_ex_rt", 32'(ex_rt), 32'h0);
      check("midstall_stall_after", 32'(stall), 32'h0);
      check("midstall_stall_count", 32'(stall_count), 32'h0);
      check("midstall_flush_count", 32'(flush_count), 32'h0);

      // Twenty load-use pairs: the 4-bit counter sticks at 15, the 16-bit one reaches 20.
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         drive_lw();
         #1;
         check($sformatf("sat%0d_lw_stall", i), 32'(stall), 32'h0);
         @(posedge clk);
         @(negedge clk);
         drive_use();
         #1;
         check($sformatf("sat%0d_use_stall", i), 32'(stall4), 32'h1);
         @(posedge clk);
         #1;
         check($sformatf("sat%0d_count4", i), 32'(stall_count4), (i < 15) ? 32'(i + 1) : 32'd15);
      end
      check("sat_stall_count16", 32'(stall_count), 32'd20);
      check("sat_flush_count4", 32'(flush_count4), 32'h0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/id_ex_stage.md
ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 SHALL have parameter CTRL_W, default 10, width of the packed control bundle.
REQ-002 SHALL have parameter CNT_W, default 16, width of each performance counter.
REQ-003 SHALL have clk  in  1  sole clock, all state updates on rising edge.
REQ-004 SHALL have reset  in  1  synchronous, active-high reset, sampled on rising edge of clk.
REQ-005 SHALL have id_valid  in  1  decode slot holds a real instruction.
REQ-006 SHALL have id_pc4, id_read_data1, id_read_data2, id_imm  in  32 each  PC+4, register-file read ports 1/2, sign-extended immediate.
REQ-007 SHALL have id_rs, id_rt, id_rd  in  5 each  decoded register fields.
REQ-008 SHALL have id_uses_rt  in  1  decode instruction reads rt as a source.
REQ-009 SHALL have id_ctrl  in  CTRL_W  packed control (reg_write, mem_to_reg, mem_read, mem_write, branch, alu_src, reg_dst, alu_op[1:0], jump).
REQ-010 SHALL have flush  in  1  taken branch/jump, squash decode slot.
REQ-011 SHALL have ex_valid, ex_pc4, ex_read_data1, ex_read_data2, ex_imm, ex_rs, ex_rt, ex_rd, ex_ctrl  out  matching widths  registered stage outputs.
REQ-012 SHALL have stall  out  1  load-use hazard, freeze PC and IF/ID.
REQ-013 SHALL have stall_count, flush_count  out  CNT_W each  saturating event counters.

Function
REQ-014 Stage register SHALL capture all id_* fields into ex_* on each rising edge when not bubbling; latency exactly one cycle.
REQ-015 hazard SHALL be combinational: ex_valid & ex_ctrl.mem_read & (ex_rt != 0) & ((ex_rt == id_rs) | (id_uses_rt & ex_rt == id_rt)) & id_valid.
REQ-016 stall SHALL equal hazard & ~flush.
REQ-017 Bubble SHALL be inserted when flush=1, or stall=1, or id_valid=0: ex_valid<=0, ex_ctrl<=0, all ex_ data/index fields <=0.
REQ-018 flush and hazard simultaneous: flush SHALL win, bubble inserted, stall=0.
REQ-019 stall SHALL never last more than one consecutive cycle for the same instruction pair (bubble clears ex_valid, removing the hazard).
REQ-020 stall_count SHALL increment by 1 on each cycle with stall=1, saturating at 2^CNT_W-1.
REQ-021 flush_count SHALL increment by 1 on each cycle with flush=1 & id_valid=1, saturating at 2^CNT_W-1.
REQ-022 A register-file write to the same register in the same cycle SHALL require no bypass here (file writes on the falling edge, read data already current).

Reset
REQ-023 On reset=1 at a rising edge all ex_* outputs, stall_count and flush_count SHALL become 0; reset SHALL override flush and stall.
REQ-024 stall SHALL read 0 in the cycle after reset (ex_valid=0).
REQ-025 Reset asserted mid-stall SHALL discard the held instruction with no counter update that cycle.

Structure
REQ-026 CTRL_W and control-bit index constants (CTRL_REG_WRITE ... CTRL_JUMP) SHALL live in shared package pipeline_pkg, also used by the control unit and EX/MEM stage.
REQ-027 The hazard compare SHALL be a sub-module hazard_detect (purely combinational); id_ex_stage owns all state.

Verification
REQ-028 lw $t1 (ex_rt=9, mem_read=1) in EX, id_rs=9 -> stall=1, next ex_valid=0, ex_ctrl=0, stall_count 0->1.
REQ-029 Same as REQ-028 with ex_rt=0 -> stall=0, id fields captured next cycle.
REQ-030 Load-use hazard with flush=1, id_valid=1 -> stall=0, bubble inserted, flush_count+1, stall_count unchanged.
REQ-031 id_rt=9 matches ex_rt=9 with id_uses_rt=0 -> stall=0, normal capture (id_read_data2=0xDEADBEEF appears on ex_read_data2).
REQ-032 CNT_W=4, 20 consecutive hazard cycles -> stall_count saturates at 15.
REQ-033 reset=1 during stall with nonzero counters -> next edge all outputs 0, stall=0.
